// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared MemRead/MemWrite codes, lane-controller state
//                encoding and the alignment check for MEM-stage accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Load codes (110/111 decode as lno)
    localparam logic [2:0] c_LNO = 3'b000;
    localparam logic [2:0] c_LW  = 3'b001;
    localparam logic [2:0] c_LH  = 3'b010;
    localparam logic [2:0] c_LHU = 3'b011;
    localparam logic [2:0] c_LB  = 3'b100;
    localparam logic [2:0] c_LBU = 3'b101;

    // Store codes
    localparam logic [1:0] c_SNO = 2'b00;
    localparam logic [1:0] c_SH  = 2'b01;
    localparam logic [1:0] c_SB  = 2'b10;
    localparam logic [1:0] c_SW  = 2'b11;

    // Lane-controller states
    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_MERGE = 1'b1;

    // A pending store decides alignment; a load is only checked without one,
    // matching the store-wins rule for illegal load+store combinations.
    function automatic logic addr_misaligned(
        input logic [2:0] mem_read,
        input logic [1:0] mem_write,
        input logic [1:0] off
    );
        logic bad;
        bad = 1'b0;
        if (mem_write != c_SNO) begin
            case (mem_write)
                c_SW:    bad = (off != 2'b00);
                c_SH:    bad = off[0];
                default: bad = 1'b0;
            endcase
        end else begin
            case (mem_read)
                c_LW:       bad = (off != 2'b00);
                c_LH, c_LHU: bad = off[0];
                default:    bad = 1'b0;
            endcase
        end
        return bad;
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_lane_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_ctrl_if
//  Description : Pipeline-side request/response and data-memory port bundle
//                of the MEM-stage byte-lane controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_lane_ctrl_if;

    logic [2:0]  MemRead;
    logic [1:0]  MemWrite;
    logic [31:0] DataAddr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        AddrErr;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_we;
    logic [31:0] dm_rdata;

    // Environment side: pipeline requests and the memory's read data
    modport master (
        output MemRead, MemWrite, DataAddr, WriteData, dm_rdata,
        input  ReadData, Stall, AddrErr, dm_addr, dm_wdata, dm_we
    );

    // Controller side
    modport slave (
        input  MemRead, MemWrite, DataAddr, WriteData, dm_rdata,
        output ReadData, Stall, AddrErr, dm_addr, dm_wdata, dm_we
    );

endinterface : mem_lane_ctrl_if
`default_nettype wire

// File: rtl/mem_lane_ctrl_lane_extract.sv
`default_nettype none
// ============================================================================
//  Module      : lane_extract
//  Description : Selects the big-endian byte/halfword lane of a memory word
//                and sign- or zero-extends it according to the load code.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_extract
    import mem_pkg::*;
(
    input  wire logic [31:0] i_word,
    input  wire logic [1:0]  i_off,
    input  wire logic [2:0]  i_mem_read,
    output logic      [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select and extension; offset 0 is the most significant lane
    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_off[1] ? i_word[15:0] : i_word[31:16];

        case (i_mem_read)
            c_LW:    o_result = i_word;
            c_LH:    o_result = {{16{w_half[15]}}, w_half};
            c_LHU:   o_result = {16'h0000, w_half};
            c_LB:    o_result = {{24{w_byte[7]}}, w_byte};
            c_LBU:   o_result = {24'h000000, w_byte};
            default: o_result = 32'h0000_0000;
        endcase
    end

endmodule : lane_extract
`default_nettype wire

// File: rtl/mem_lane_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_ctrl
//  Description : MEM-stage byte-lane controller. Combinational loads and sw,
//                two-cycle read-modify-write for sb/sh with one stall cycle,
//                misaligned accesses blocked and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_ctrl
    import mem_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    mem_lane_ctrl_if.slave     bus
);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [31:0] r_hold;
    logic        w_hold_ld;

    logic [1:0]  w_off;
    logic        w_err;
    logic        w_is_sub;
    logic [31:0] w_ext;
    logic [31:0] w_merged;
    logic        w_stall;
    logic        w_we;
    logic [31:0] w_rdata;
    logic [31:0] w_wdata;
    logic        w_unused;

    assign w_off    = bus.DataAddr[1:0];
    assign w_err    = addr_misaligned(bus.MemRead, bus.MemWrite, w_off);
    assign w_is_sub = (bus.MemWrite == c_SB) || (bus.MemWrite == c_SH);
    assign w_unused = &{1'b0, bus.DataAddr[31:12]};

    lane_extract u_lane_extract (
        .i_word     (bus.dm_rdata),
        .i_off      (w_off),
        .i_mem_read (bus.MemRead),
        .o_result   (w_ext)
    );

    // Insert the store lane into the word captured during the stall cycle
    always_comb begin
        w_merged = r_hold;
        if (bus.MemWrite == c_SB) begin
            case (w_off)
                2'd0:    w_merged[31:24] = bus.WriteData[7:0];
                2'd1:    w_merged[23:16] = bus.WriteData[7:0];
                2'd2:    w_merged[15:8]  = bus.WriteData[7:0];
                default: w_merged[7:0]   = bus.WriteData[7:0];
            endcase
        end else if (w_off[1]) begin
            w_merged[15:0]  = bus.WriteData[15:0];
        end else begin
            w_merged[31:16] = bus.WriteData[15:0];
        end
    end

    // Next state and outputs; reset or a misaligned access suppresses all
    // side effects and parks the machine in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_we        = 1'b0;
        w_hold_ld   = 1'b0;
        w_rdata     = 32'h0000_0000;
        w_wdata     = bus.WriteData;
        if (!rst && !w_err) begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_is_sub) begin
                        w_stall     = 1'b1;
                        w_hold_ld   = 1'b1;
                        w_state_nxt = c_S_MERGE;
                    end else if (bus.MemWrite == c_SW) begin
                        w_we = 1'b1;
                    end else begin
                        w_rdata = w_ext;
                    end
                end
                c_S_MERGE: begin
                    w_state_nxt = c_S_IDLE;
                    if (w_is_sub) begin
                        w_we    = 1'b1;
                        w_wdata = w_merged;
                    end
                end
                default: w_state_nxt = c_S_IDLE;
            endcase
        end else begin
            w_state_nxt = c_S_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Capture the current memory word at the start of a sub-word store
    always_ff @(posedge clk) begin
        if (rst)            r_hold <= 32'h0000_0000;
        else if (w_hold_ld) r_hold <= bus.dm_rdata;
    end

    assign bus.ReadData = w_rdata;
    assign bus.Stall    = w_stall;
    assign bus.AddrErr  = w_err;
    assign bus.dm_addr  = bus.DataAddr[11:2];
    assign bus.dm_wdata = w_wdata;
    assign bus.dm_we    = w_we;

endmodule : mem_lane_ctrl
`default_nettype wire

// File: tb/tb_mem_lane_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_lane_ctrl
//  Description : Scoreboard bench for mem_lane_ctrl with a word memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lane_ctrl;
    import mem_pkg::*;

    typedef struct {
        int          cyc;
        string       name;
        logic        stall;
        logic        we;
        logic        err;
        logic [31:0] rd;
        logic [31:0] wd;
        logic [9:0]  addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        q[$];
    logic [31:0] mem [0:1023];

    mem_lane_ctrl_if bus();

    mem_lane_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: combinational read, write on the rising edge
    assign bus.dm_rdata = mem[bus.dm_addr];
    always @(posedge clk) if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares whatever the DUT presents in a cycle that has an entry
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".Stall"},    {31'd0, bus.Stall},   {31'd0, e.stall});
            chk({e.name, ".dm_we"},    {31'd0, bus.dm_we},   {31'd0, e.we});
            chk({e.name, ".AddrErr"},  {31'd0, bus.AddrErr}, {31'd0, e.err});
            chk({e.name, ".ReadData"}, bus.ReadData, e.rd);
            chk({e.name, ".dm_addr"},  {22'd0, bus.dm_addr}, {22'd0, e.addr});
            if (e.we) chk({e.name, ".dm_wdata"}, bus.dm_wdata, e.wd);
        end
    end

    task automatic step(input string nm, input logic r, input logic [2:0] mr,
                        input logic [1:0] mw, input logic [31:0] a, input logic [31:0] wd,
                        input logic es, input logic ew, input logic ee,
                        input logic [31:0] erd, input logic [31:0] ewd);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.MemRead   = mr;
        bus.MemWrite  = mw;
        bus.DataAddr  = a;
        bus.WriteData = wd;
        e.cyc = cyc; e.name = nm; e.stall = es; e.we = ew; e.err = ee;
        e.rd = erd; e.wd = ewd; e.addr = a[11:2];
        q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h040] = 32'h11223344;
        mem[10'h080] = 32'h80FF7F01;
        mem[10'h0C0] = 32'hAABBCCDD;
        bus.MemRead = c_LNO; bus.MemWrite = c_SNO; bus.DataAddr = 32'h0; bus.WriteData = 32'h0;

        // Reset and idle
        step("rst0",  1, c_LNO, c_SNO, 32'h000, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        step("rst1",  1, c_LNO, c_SNO, 32'h000, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        step("idle",  0, c_LNO, c_SNO, 32'h000, 32'h0, 0, 0, 0, 32'h0, 32'h0);

        // Loads on 0x11223344
        step("lb101", 0, c_LB,  c_SNO, 32'h101, 32'h0, 0, 0, 0, 32'h00000022, 32'h0);
        step("lh102", 0, c_LH,  c_SNO, 32'h102, 32'h0, 0, 0, 0, 32'h00003344, 32'h0);
        step("lw100", 0, c_LW,  c_SNO, 32'h100, 32'h0, 0, 0, 0, 32'h11223344, 32'h0);
        step("l110",  0, 3'b110, c_SNO, 32'h100, 32'h0, 0, 0, 0, 32'h0, 32'h0);

        // Extension on 0x80FF7F01
        step("lb200",  0, c_LB,  c_SNO, 32'h200, 32'h0, 0, 0, 0, 32'hFFFFFF80, 32'h0);
        step("lbu200", 0, c_LBU, c_SNO, 32'h200, 32'h0, 0, 0, 0, 32'h00000080, 32'h0);
        step("lh200",  0, c_LH,  c_SNO, 32'h200, 32'h0, 0, 0, 0, 32'hFFFF80FF, 32'h0);
        step("lhu202", 0, c_LHU, c_SNO, 32'h202, 32'h0, 0, 0, 0, 32'h00007F01, 32'h0);

        // sb 0x55 to 0x302 on 0xAABBCCDD
        step("sb302a", 0, c_LNO, c_SB, 32'h302, 32'h55, 1, 0, 0, 32'h0, 32'h0);
        step("sb302b", 0, c_LNO, c_SB, 32'h302, 32'h55, 0, 1, 0, 32'h0, 32'hAABB55DD);
        step("lw300a", 0, c_LW,  c_SNO, 32'h300, 32'h0, 0, 0, 0, 32'hAABB55DD, 32'h0);

        // Restore, then sh 0x1234 to 0x300
        step("swrst",  0, c_LNO, c_SW, 32'h300, 32'hAABBCCDD, 0, 1, 0, 32'h0, 32'hAABBCCDD);
        step("sh300a", 0, c_LNO, c_SH, 32'h300, 32'h1234, 1, 0, 0, 32'h0, 32'h0);
        step("sh300b", 0, c_LNO, c_SH, 32'h300, 32'h1234, 0, 1, 0, 32'h0, 32'h1234CCDD);
        step("lw300b", 0, c_LW,  c_SNO, 32'h300, 32'h0, 0, 0, 0, 32'h1234CCDD, 32'h0);

        // sw single cycle
        step("sw300",  0, c_LNO, c_SW, 32'h300, 32'hDEADBEEF, 0, 1, 0, 32'h0, 32'hDEADBEEF);
        step("lw300c", 0, c_LW,  c_SNO, 32'h300, 32'h0, 0, 0, 0, 32'hDEADBEEF, 32'h0);

        // Misaligned accesses
        step("errlw",  0, c_LW,  c_SNO, 32'h101, 32'h0, 0, 0, 1, 32'h0, 32'h0);
        step("errsh",  0, c_LNO, c_SH,  32'h303, 32'h9999, 0, 0, 1, 32'h0, 32'h0);
        step("errlh",  0, c_LH,  c_SNO, 32'h001, 32'h0, 0, 0, 1, 32'h0, 32'h0);
        step("lw100b", 0, c_LW,  c_SNO, 32'h100, 32'h0, 0, 0, 0, 32'h11223344, 32'h0);
        step("lw300d", 0, c_LW,  c_SNO, 32'h300, 32'h0, 0, 0, 0, 32'hDEADBEEF, 32'h0);

        // Back-to-back sb, sb
        step("sbb0a",  0, c_LNO, c_SB, 32'h300, 32'hAA, 1, 0, 0, 32'h0, 32'h0);
        step("sbb0b",  0, c_LNO, c_SB, 32'h300, 32'hAA, 0, 1, 0, 32'h0, 32'hAAADBEEF);
        step("sbb3a",  0, c_LNO, c_SB, 32'h303, 32'hBB, 1, 0, 0, 32'h0, 32'h0);
        step("sbb3b",  0, c_LNO, c_SB, 32'h303, 32'hBB, 0, 1, 0, 32'h0, 32'hAAADBEBB);
        step("lw300e", 0, c_LW,  c_SNO, 32'h300, 32'h0, 0, 0, 0, 32'hAAADBEBB, 32'h0);

        // Load and store together: store wins, ReadData 0
        step("ldst",   0, c_LW,  c_SW, 32'h100, 32'h11223344, 0, 1, 0, 32'h0, 32'h11223344);

        // Reset during MERGE aborts the store
        step("sbra",   0, c_LNO, c_SB, 32'h301, 32'h77, 1, 0, 0, 32'h0, 32'h0);
        step("sbrb",   1, c_LNO, c_SB, 32'h301, 32'h77, 0, 0, 0, 32'h0, 32'h0);
        step("lw300f", 0, c_LW,  c_SNO, 32'h300, 32'h0, 0, 0, 0, 32'hAAADBEBB, 32'h0);
        step("idle2",  0, c_LNO, c_SNO, 32'h000, 32'h0, 0, 0, 0, 32'h0, 32'h0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mem_lane_ctrl
`default_nettype wire
